mux_lanes_rr: RTL and testbench



---
 rtl/mux_lanes_rr_pkg.sv | 15 +
 rtl/mux_lanes_rr_if.sv | 29 ++
 rtl/mux_lanes_rr_lane_ctr.sv | 30 +++
 rtl/mux_lanes_rr.sv | 57 +++++
 tb/tb_mux_lanes_rr.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_lanes_rr_pkg.sv
// rtl/mux_lanes_rr_pkg.sv - shared phy_tx constants and lane-index width helper
package phy_tx_pkg;

   localparam int PHY_LANES = 4;
   localparam int PHY_WIDTH = 8;

   localparam bit POLICY_ZERO = 1'b0;
   localparam bit POLICY_HOLD = 1'b1;

   // Lane index width; a single lane still needs one bit of index.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_lanes_rr_if.sv
// rtl/mux_lanes_rr_if.sv - parallel lane input and serialized output bundle
interface mux_lanes_rr_if
   import phy_tx_pkg::*;
#(
   parameter int LANES = PHY_LANES,
   parameter int WIDTH = PHY_WIDTH
);

   localparam int CW = clog2_min1(LANES);

   logic [LANES*WIDTH-1:0] data_in;
   logic [LANES-1:0]       valid_in;
   logic                   align;
   logic [WIDTH-1:0]       data_out;
   logic                   valid_out;
   logic [CW-1:0]          lane_out;
   logic                   frame_start;

   modport master (
      output data_in, valid_in, align,
      input  data_out, valid_out, lane_out, frame_start
   );

   modport slave (
      input  data_in, valid_in, align,
      output data_out, valid_out, lane_out, frame_start
   );

endinterface

// File: rtl/mux_lanes_rr_lane_ctr.sv
// rtl/mux_lanes_rr_lane_ctr.sv - modulo-LANES lane counter with align clear and snapshot enable
module lane_ctr
   import phy_tx_pkg::*;
#(
   parameter int LANES = PHY_LANES,
   parameter int CW    = clog2_min1(LANES)
) (
   input  logic          clk_4f,
   input  logic          reset_L,
   input  logic          align,
   output logic [CW-1:0] cnt,
   output logic          snap_en
);

   localparam logic [CW-1:0] LAST = CW'(LANES - 1);

   // Align and the natural wrap both restart the frame, so one enable covers both.
   assign snap_en = (cnt == LAST) | align;

   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         cnt <= '0;
      end else if (snap_en) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/mux_lanes_rr.sv
// rtl/mux_lanes_rr.sv - N:1 round-robin lane serializer on clk_4f
module mux_lanes_rr
   import phy_tx_pkg::*;
#(
   parameter int LANES           = PHY_LANES,
   parameter int WIDTH           = PHY_WIDTH,
   parameter bit HOLD_ON_INVALID = POLICY_HOLD
) (
   input  logic           clk_4f,
   input  logic           reset_L,
   mux_lanes_rr_if.slave  bus
);

   localparam int CW = clog2_min1(LANES);

   logic [CW-1:0]               cnt;
   logic                        snap_en;
   logic [LANES-1:0][WIDTH-1:0] snap_data;
   logic [LANES-1:0]            snap_valid;

   lane_ctr #(
      .LANES (LANES),
      .CW    (CW)
   ) u_lane_ctr (
      .clk_4f  (clk_4f),
      .reset_L (reset_L),
      .align   (bus.align),
      .cnt     (cnt),
      .snap_en (snap_en)
   );

   // Output stage reads the pre-edge snapshot, so a frame lands one edge after capture.
   always_ff @(posedge clk_4f) begin
      if (!reset_L) begin
         snap_data       <= '0;
         snap_valid      <= '0;
         bus.data_out    <= '0;
         bus.valid_out   <= 1'b0;
         bus.lane_out    <= '0;
         bus.frame_start <= 1'b0;
      end else begin
         if (snap_en) begin
            snap_data  <= bus.data_in;
            snap_valid <= bus.valid_in;
         end
         bus.lane_out    <= cnt;
         bus.frame_start <= (cnt == '0);
         bus.valid_out   <= snap_valid[cnt];
         if (snap_valid[cnt]) begin
            bus.data_out <= snap_data[cnt];
         end else if (HOLD_ON_INVALID == POLICY_ZERO) begin
            bus.data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mux_lanes_rr.sv
// tb/tb_mux_lanes_rr.sv - directed self-checking bench for mux_lanes_rr
module tb_mux_lanes_rr;

   logic clk_4f;
   logic reset_L;
   int   checks = 0;
   int   errors = 0;
   int   cnt4 = 0;
   int   cnt3 = 0;

   mux_lanes_rr_if #(.LANES(4), .WIDTH(8)) ifa ();
   mux_lanes_rr_if #(.LANES(4), .WIDTH(8)) ifb ();
   mux_lanes_rr_if #(.LANES(3), .WIDTH(8)) ifc ();

   assign ifb.data_in  = ifa.data_in;
   assign ifb.valid_in = ifa.valid_in;
   assign ifb.align    = ifa.align;

   mux_lanes_rr #(.LANES(4), .WIDTH(8), .HOLD_ON_INVALID(1'b1)) u_hold (
      .clk_4f(clk_4f), .reset_L(reset_L), .bus(ifa));
   mux_lanes_rr #(.LANES(4), .WIDTH(8), .HOLD_ON_INVALID(1'b0)) u_zero (
      .clk_4f(clk_4f), .reset_L(reset_L), .bus(ifb));
   mux_lanes_rr #(.LANES(3), .WIDTH(8), .HOLD_ON_INVALID(1'b1)) u_three (
      .clk_4f(clk_4f), .reset_L(reset_L), .bus(ifc));

   initial begin
      clk_4f = 1'b0;
      forever #5 clk_4f = ~clk_4f;
   end

   // Tracks the expected pre-edge lane counter of each frame so tasks can find snapshot edges.
   task automatic tick();
      @(posedge clk_4f);
      if (!reset_L) begin
         cnt4 = 0;
         cnt3 = 0;
      end else begin
         cnt4 = (ifa.align || cnt4 == 3) ? 0 : cnt4 + 1;
         cnt3 = (cnt3 == 2) ? 0 : cnt3 + 1;
      end
      #1;
   endtask

   task automatic load4(input logic [31:0] d, input logic [3:0] v);
      bit done = 1'b0;
      ifa.data_in  = d;
      ifa.valid_in = v;
      for (int i = 0; i < 8 && !done; i++) begin
         done = (cnt4 == 3);
         tick();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL load4_timeout got no snapshot edge within 8 cycles");
      end
      ifa.data_in  = 32'hEEEE_EEEE;
      ifa.valid_in = 4'h0;
   endtask

   task automatic test_reset();
      reset_L = 1'b0;
      ifa.align = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      ifa.align = 1'b0;
      checks++;
      if ({ifa.data_out, ifa.valid_out, ifa.lane_out, ifa.frame_start} !== 12'h000) begin
         errors++;
         $display("FAIL reset_hold got %h/%b/%0d/%b required 0/0/0/0",
                  ifa.data_out, ifa.valid_out, ifa.lane_out, ifa.frame_start);
      end
      checks++;
      if ({ifb.data_out, ifb.valid_out, ifc.data_out, ifc.valid_out, ifc.lane_out, ifc.frame_start} !== 21'h0) begin
         errors++;
         $display("FAIL reset_others got zero:%h/%b three:%h/%b/%0d/%b required all 0",
                  ifb.data_out, ifb.valid_out, ifc.data_out, ifc.valid_out, ifc.lane_out, ifc.frame_start);
      end
      reset_L = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (ifa.lane_out !== 2'(i % 4) || ifa.frame_start !== (i % 4 == 0) ||
             ifa.valid_out !== 1'b0 || ifa.data_out !== 8'h00) begin
            errors++;
            $display("FAIL release_cycle%0d got lane %0d fs %b v %b d %h required lane %0d fs %b v 0 d 00",
                     i, ifa.lane_out, ifa.frame_start, ifa.valid_out, ifa.data_out, i % 4, (i % 4 == 0));
         end
      end
   endtask

   task automatic test_nominal();
      logic [7:0] exp_d [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      load4({8'hDD, 8'hCC, 8'hBB, 8'hAA}, 4'hF);
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (ifa.data_out !== exp_d[k] || ifa.valid_out !== 1'b1 ||
             ifa.lane_out !== 2'(k) || ifa.frame_start !== (k == 0)) begin
            errors++;
            $display("FAIL nominal_lane%0d got d %h v %b lane %0d fs %b required d %h v 1 lane %0d fs %b",
                     k, ifa.data_out, ifa.valid_out, ifa.lane_out, ifa.frame_start, exp_d[k], k, (k == 0));
         end
         checks++;
         if (ifb.data_out !== exp_d[k]) begin
            errors++;
            $display("FAIL nominal_zero_lane%0d got %h required %h", k, ifb.data_out, exp_d[k]);
         end
      end
   endtask

   task automatic test_invalid_policy();
      logic [7:0] exp_hold [4] = '{8'hAA, 8'hBB, 8'hBB, 8'hDD};
      logic [7:0] exp_zero [4] = '{8'hAA, 8'hBB, 8'h00, 8'hDD};
      logic [3:0] exp_v = 4'b1011;
      load4({8'hDD, 8'hCC, 8'hBB, 8'hAA}, 4'b1011);
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (ifa.data_out !== exp_hold[k] || ifa.valid_out !== exp_v[k] || ifa.lane_out !== 2'(k)) begin
            errors++;
            $display("FAIL hold_lane%0d got d %h v %b lane %0d required d %h v %b lane %0d",
                     k, ifa.data_out, ifa.valid_out, ifa.lane_out, exp_hold[k], exp_v[k], k);
         end
         checks++;
         if (ifb.data_out !== exp_zero[k] || ifb.valid_out !== exp_v[k]) begin
            errors++;
            $display("FAIL zero_lane%0d got d %h v %b required d %h v %b",
                     k, ifb.data_out, ifb.valid_out, exp_zero[k], exp_v[k]);
         end
      end
   endtask

   task automatic test_mid_align();
      logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      load4({8'hD4, 8'hC3, 8'hB2, 8'hA1}, 4'hF);
      tick();
      checks++;
      if (ifa.data_out !== 8'hA1 || ifa.lane_out !== 2'd0) begin
         errors++;
         $display("FAIL align_pre got d %h lane %0d required d a1 lane 0", ifa.data_out, ifa.lane_out);
      end
      ifa.align    = 1'b1;
      ifa.data_in  = {8'h44, 8'h33, 8'h22, 8'h11};
      ifa.valid_in = 4'hF;
      tick();
      checks++;
      if (ifa.data_out !== 8'hB2 || ifa.lane_out !== 2'd1 || ifa.valid_out !== 1'b1) begin
         errors++;
         $display("FAIL align_edge got d %h lane %0d v %b required d b2 lane 1 v 1",
                  ifa.data_out, ifa.lane_out, ifa.valid_out);
      end
      ifa.align    = 1'b0;
      ifa.data_in  = 32'hEEEE_EEEE;
      ifa.valid_in = 4'h0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (ifa.data_out !== exp_d[k] || ifa.lane_out !== 2'(k) ||
             ifa.frame_start !== (k == 0) || ifa.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL align_new_lane%0d got d %h lane %0d fs %b v %b required d %h lane %0d fs %b v 1",
                     k, ifa.data_out, ifa.lane_out, ifa.frame_start, ifa.valid_out, exp_d[k], k, (k == 0));
         end
      end
      tick();
      checks++;
      if (ifa.valid_out !== 1'b0 || ifa.data_out !== 8'h44 || ifa.lane_out !== 2'd0) begin
         errors++;
         $display("FAIL align_after got d %h v %b lane %0d required d 44 v 0 lane 0",
                  ifa.data_out, ifa.valid_out, ifa.lane_out);
      end
   endtask

   task automatic test_align_wrap();
      logic [7:0] exp_d [4] = '{8'h05, 8'h06, 8'h07, 8'h08};
      ifa.data_in  = {8'h08, 8'h07, 8'h06, 8'h05};
      ifa.valid_in = 4'hF;
      for (int i = 0; i < 8 && cnt4 != 3; i++) tick();
      ifa.align = 1'b1;
      tick();
      checks++;
      if (ifa.lane_out !== 2'd3) begin
         errors++;
         $display("FAIL wrap_edge got lane %0d required 3", ifa.lane_out);
      end
      ifa.align    = 1'b0;
      ifa.data_in  = 32'hEEEE_EEEE;
      ifa.valid_in = 4'h0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (ifa.data_out !== exp_d[k] || ifa.lane_out !== 2'(k) || ifa.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL wrap_lane%0d got d %h lane %0d v %b required d %h lane %0d v 1",
                     k, ifa.data_out, ifa.lane_out, ifa.valid_out, exp_d[k], k);
         end
      end
      tick();
      checks++;
      if (ifa.valid_out !== 1'b0 || ifa.lane_out !== 2'd0 || ifa.frame_start !== 1'b1) begin
         errors++;
         $display("FAIL wrap_after got v %b lane %0d fs %b required v 0 lane 0 fs 1",
                  ifa.valid_out, ifa.lane_out, ifa.frame_start);
      end
   endtask

   task automatic test_three_lanes();
      logic [7:0] exp_d;
      bit done = 1'b0;
      ifc.data_in  = {8'h63, 8'h62, 8'h61};
      ifc.valid_in = 3'b111;
      for (int i = 0; i < 6 && !done; i++) begin
         done = (cnt3 == 2);
         tick();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL three_sync_timeout got no snapshot edge within 6 cycles");
      end
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i == 0) ifc.data_in = {8'h73, 8'h72, 8'h71};
         exp_d = ((i < 3) ? 8'h61 : 8'h71) + 8'(i % 3);
         checks++;
         if (ifc.lane_out !== 2'(i % 3) || ifc.data_out !== exp_d ||
             ifc.valid_out !== 1'b1 || ifc.frame_start !== (i % 3 == 0)) begin
            errors++;
            $display("FAIL three_cycle%0d got lane %0d d %h v %b fs %b required lane %0d d %h v 1 fs %b",
                     i, ifc.lane_out, ifc.data_out, ifc.valid_out, ifc.frame_start, i % 3, exp_d, (i % 3 == 0));
         end
      end
   endtask

   initial begin
      reset_L      = 1'b0;
      ifa.data_in  = '0;
      ifa.valid_in = '0;
      ifa.align    = 1'b0;
      ifc.data_in  = '0;
      ifc.valid_in = '0;
      ifc.align    = 1'b0;
      test_reset();
      test_nominal();
      test_invalid_policy();
      test_mid_align();
      test_align_wrap();
      test_three_lanes();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
